// File: rtl/mem_pkg.sv
// mem_pkg: shared opcodes, FSM states, byte-enable constants and access-size helpers for the MEM stage
package mem_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_B0   = 4'b1000;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic logic is_byte(input logic [5:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_SB;
  endfunction
  function automatic logic is_half(input logic [5:0] op);
    return op == OP_LH || op == OP_LHU || op == OP_SH;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: big-endian load lane select and sign/zero extension (rdata, off, op -> data)
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = off[1] ? (off[0] ? rdata[7:0] : rdata[15:8]) : (off[0] ? rdata[23:16] : rdata[31:24]);
    h = off[1] ? rdata[15:0] : rdata[31:16];
    data = op == OP_LB  ? {{24{b[7]}}, b} :
           op == OP_LBU ? {24'h0, b} :
           op == OP_LH  ? {{16{h[15]}}, h} :
           op == OP_LHU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage (EX/MEM fields in, dmem req/ack port, stall/addr_err out, registered MEM/WB fields out)
module mem_stage
  import mem_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegWrite_i,
  input  logic [1:0]         RegData_i,
  input  logic [5:0]         Op_i,
  input  logic [31:0]        ALUResult_i,
  input  logic [31:0]        Data_i,
  input  logic [5:0]         Rd_i,
  input  logic [31:0]        c0Data_i,
  input  logic               mfc0_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               flush,
  output logic               mem_stall,
  output logic               addr_err,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               RegWrite_o,
  output logic [1:0]         RegData_o,
  output logic [31:0]        MemData_o,
  output logic [31:0]        ALUResult_o,
  output logic [5:0]         Rd_o,
  output logic [31:0]        c0Data_o,
  output logic               mfc0_o
);
  state_t      state, state_n;
  logic        kill, kill_n, access, byte_op, half_op, mis, go, done, hold;
  logic [1:0]  a;
  logic [31:0] ld;
  load_align u_align (.rdata(dmem_rdata), .off(a), .op(Op_i), .data(ld));
  always_comb begin
    a          = ALUResult_i[1:0];
    access     = MemRead_i | MemWrite_i;
    byte_op    = is_byte(Op_i);
    half_op    = is_half(Op_i);
    mis        = access & (half_op ? a[0] : ~byte_op & (|a));
    addr_err   = (state == IDLE) & mis & ~flush;
    go         = (state == IDLE) & access & ~mis & ~flush;
    // reset gates the request so an outstanding access vanishes immediately
    dmem_req   = rst_n & ((state == WAIT) | go);
    dmem_we    = dmem_req & MemWrite_i;
    dmem_addr  = {ALUResult_i[DMEM_AW-1:2], 2'b00};
    dmem_be    = byte_op ? BE_B0 >> a : half_op ? (a[1] ? BE_LO : BE_HI) : BE_WORD;
    dmem_wdata = byte_op ? {4{Data_i[7:0]}} : half_op ? {2{Data_i[15:0]}} : Data_i;
    mem_stall  = dmem_req & ~dmem_ack;
    done       = dmem_req & dmem_ack;
    state_n    = state == IDLE ? (mem_stall ? WAIT : IDLE) : (dmem_ack ? IDLE : WAIT);
    // a flush seen while waiting is remembered so the completing edge loads a bubble
    kill_n     = (state_n == WAIT) & (kill | flush);
    hold       = mem_stall | flush | kill;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kill        <= 1'b0;
      RegWrite_o  <= 1'b0;
      RegData_o   <= '0;
      MemData_o   <= '0;
      ALUResult_o <= '0;
      Rd_o        <= '0;
      c0Data_o    <= '0;
      mfc0_o      <= 1'b0;
    end else begin
      state      <= state_n;
      kill       <= kill_n;
      RegWrite_o <= RegWrite_i & ~hold & ~mis;
      if (!hold) begin
        RegData_o   <= RegData_i;
        ALUResult_o <= ALUResult_i;
        Rd_o        <= Rd_i;
        c0Data_o    <= c0Data_i;
        mfc0_o      <= mfc0_i;
        if (done && MemRead_i) MemData_o <= ld;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a variable-latency memory responder
module tb_mem_stage;
  import mem_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        RegWrite_i = 0, mfc0_i = 0, MemRead_i = 0, MemWrite_i = 0, flush = 0, dmem_ack = 0;
  logic [1:0]  RegData_i = 0;
  logic [5:0]  Op_i = 0, Rd_i = 0;
  logic [31:0] ALUResult_i = 0, Data_i = 0, c0Data_i = 0, dmem_rdata = 0;
  logic        mem_stall, addr_err, dmem_req, dmem_we, RegWrite_o, mfc0_o;
  logic [31:0] dmem_addr, dmem_wdata, MemData_o, ALUResult_o, c0Data_o;
  logic [3:0]  dmem_be;
  logic [1:0]  RegData_o;
  logic [5:0]  Rd_o;
  always #5 clk = ~clk;
  mem_stage #(.DMEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite_i(RegWrite_i), .RegData_i(RegData_i), .Op_i(Op_i),
    .ALUResult_i(ALUResult_i), .Data_i(Data_i), .Rd_i(Rd_i), .c0Data_i(c0Data_i), .mfc0_i(mfc0_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .flush(flush), .mem_stall(mem_stall),
    .addr_err(addr_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWrite_o(RegWrite_o), .RegData_o(RegData_o), .MemData_o(MemData_o), .ALUResult_o(ALUResult_o),
    .Rd_o(Rd_o), .c0Data_o(c0Data_o), .mfc0_o(mfc0_o)
  );
  typedef struct {
    logic        rw;
    logic [1:0]  rdsel;
    logic [31:0] md, alu, c0;
    logic [5:0]  rd;
    logic        mfc0;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [1:0] off, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[31-8*off -: 8];
    h = off[1] ? r[15:0] : r[31:16];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return r;
    endcase
  endfunction
  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b1000 >> off;
      OP_LH, OP_LHU, OP_SH: return off[1] ? 4'b0011 : 4'b1100;
      default:              return 4'b1111;
    endcase
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      OP_SH:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("RegWrite_o", RegWrite_o, e.rw);
    chk("RegData_o", RegData_o, e.rdsel);
    chk("MemData_o", MemData_o, e.md);
    chk("ALUResult_o", ALUResult_o, e.alu);
    chk("Rd_o", Rd_o, e.rd);
    chk("c0Data_o", c0Data_o, e.c0);
    chk("mfc0_o", mfc0_o, e.mfc0);
  endtask
  task automatic run(input logic [5:0] op, input logic rd_en, input logic wr_en, input logic [31:0] addr,
                     input logic [31:0] data, input logic [5:0] rd, input logic rw, input int lat,
                     input logic [31:0] rdata, input logic fli, input logic flw);
    logic acc, bo, ho, mis, req, fl;
    @(negedge clk);
    pop_check();
    Op_i = op; MemRead_i = rd_en; MemWrite_i = wr_en; ALUResult_i = addr; Data_i = data;
    Rd_i = rd; RegWrite_i = rw; RegData_i = addr[5:4]; c0Data_i = ~data; mfc0_i = addr[6];
    flush = fli; dmem_ack = (lat == 0); dmem_rdata = rdata;
    acc = rd_en | wr_en;
    bo  = op inside {OP_LB, OP_LBU, OP_SB};
    ho  = op inside {OP_LH, OP_LHU, OP_SH};
    mis = acc && (ho ? addr[0] : !bo && addr[1:0] != 2'b00);
    req = acc && !mis && !fli;
    #1;
    chk("dmem_req", dmem_req, req);
    chk("mem_stall", mem_stall, req && lat != 0);
    chk("addr_err", addr_err, acc && mis && !fli);
    if (req) begin
      chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("dmem_we", dmem_we, wr_en);
      chk("dmem_be", dmem_be, ref_be(op, addr[1:0]));
      if (wr_en) chk("dmem_wdata", dmem_wdata, ref_wdata(op, data));
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        chk("RegWrite_o_stall", RegWrite_o, 0);
        flush = flw && i == 1;
        dmem_ack = (i == lat);
        #1;
        chk("dmem_req_hold", dmem_req, 1);
        chk("mem_stall_wait", mem_stall, i != lat);
      end
    end
    fl = fli || (flw && req && lat > 0);
    if (!fl) begin
      m.rdsel = addr[5:4]; m.alu = addr; m.rd = rd; m.c0 = ~data; m.mfc0 = addr[6];
      if (req && rd_en) m.md = ref_load(op, addr[1:0], rdata);
    end
    m.rw = rw && !fl && !mis;
    q.push_back(m);
  endtask
  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [31:0] a;
    int lat;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h00};
    m = '{default: 0};
    #12;
    chk("rst_RegWrite_o", RegWrite_o, 0);
    chk("rst_MemData_o", MemData_o, 0);
    chk("rst_ALUResult_o", ALUResult_o, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_mem_stall", mem_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(OP_LW,  1, 0, 32'h100, 32'h0, 6'd5, 1, 3, 32'hDEADBEEF, 0, 0);
    run(OP_LB,  1, 0, 32'h103, 32'h0, 6'd6, 1, 0, 32'h123456F0, 0, 0);
    run(OP_LBU, 1, 0, 32'h103, 32'h0, 6'd7, 1, 0, 32'h123456F0, 0, 0);
    run(OP_SH,  0, 1, 32'h202, 32'h0000ABCD, 6'd0, 0, 1, 32'h0, 0, 0);
    chk("sh_be_const", dmem_be, 4'b0011);
    chk("sh_wdata_const", dmem_wdata, 32'hABCDABCD);
    run(6'h00,  0, 0, 32'h55, 32'h1, 6'd8, 1, 0, 32'hFFFFFFFF, 0, 0);
    run(OP_LW,  1, 0, 32'h101, 32'h0, 6'd9, 1, 0, 32'h11111111, 0, 0);
    run(OP_SW,  0, 1, 32'h300, 32'hCAFEF00D, 6'd0, 0, 2, 32'h0, 0, 1);
    run(OP_LW,  1, 0, 32'h104, 32'h0, 6'd10, 1, 0, 32'h22222222, 1, 0);
    run(OP_LH,  1, 0, 32'h102, 32'h0, 6'd11, 1, 1, 32'h12348001, 0, 0);
    run(OP_LHU, 1, 0, 32'h100, 32'h0, 6'd12, 1, 0, 32'h9ABC0000, 0, 0);
    run(OP_SB,  0, 1, 32'h101, 32'h000000AB, 6'd0, 0, 0, 32'h0, 0, 0);
    run(OP_LH,  1, 0, 32'h101, 32'h0, 6'd13, 1, 0, 32'h0, 0, 0);
    run(OP_LW,  1, 0, 32'h400, 32'h0, 6'd14, 1, 2, 32'h0BADCAFE, 0, 1);
    for (int k = 0; k < 30; k++) begin
      op  = ops[$urandom_range(0, 8)];
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (op inside {OP_LH, OP_LHU, OP_SH}) ? {a[1], 1'b0} : 2'b00;
      lat = $urandom_range(0, 3);
      run(op, op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU}, op inside {OP_SB, OP_SH, OP_SW}, a,
          $urandom, 6'($urandom), 1'($urandom), lat, $urandom,
          $urandom_range(0, 7) == 0, lat > 0 && $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    pop_check();
    Op_i = OP_LW; MemRead_i = 1; MemWrite_i = 0; ALUResult_i = 32'h300; RegWrite_i = 1; Rd_i = 6'd3;
    flush = 0; dmem_ack = 0;
    #1;
    chk("rstw_req_issue", dmem_req, 1);
    @(negedge clk);
    #1;
    chk("rstw_req_wait", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_dmem_req", dmem_req, 0);
    chk("rstw_mem_stall", mem_stall, 0);
    chk("rstw_RegWrite_o", RegWrite_o, 0);
    chk("rstw_MemData_o", MemData_o, 0);
    chk("rstw_ALUResult_o", ALUResult_o, 0);
    chk("rstw_Rd_o", Rd_o, 0);
    chk("rstw_c0Data_o", c0Data_o, 0);
    chk("rstw_RegData_o", RegData_o, 0);
    chk("rstw_mfc0_o", mfc0_o, 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    Op_i = 0; MemRead_i = 0; ALUResult_i = 0; RegWrite_i = 0; Rd_i = 0; Data_i = 0;
    c0Data_i = 0; mfc0_i = 0; RegData_i = 0;
    rst_n = 1'b1;
    m = '{default: 0};
    q.delete();
    run(OP_LW, 1, 0, 32'h500, 32'h0, 6'd4, 1, 2, 32'h5A5A5A5A, 0, 0);
    run(OP_LB, 1, 0, 32'h501, 32'h0, 6'd2, 1, 0, 32'h00800000, 0, 0);
    @(negedge clk);
    pop_check();
    MemRead_i = 0; MemWrite_i = 0; dmem_ack = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
